// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the bit-serial subtractor.
package sub_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int SUB_W = 8;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational one-bit difference/borrow cell.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with start/busy/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W);

    state_t        state;
    logic [W-1:0]  a_sh, b_sh, res;
    logic [CW-1:0] cnt;
    logic          bor, d, bor_next;

    full_subtractor u_cell (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Bin (bor),
        .D   (d),
        .Bout(bor_next)
    );

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // On the last SHIFT edge a_sh[0]/b_sh[0] hold the original operand MSBs and d is the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    bor   <= 1'b0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[W-1:1]};
                    bor  <= bor_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state      <= DONE;
                        diff       <= {d, res[W-1:1]};
                        borrow_out <= bor_next;
                        ovf        <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor at W=8 and W=16.
module tb_serial_subtractor;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic        bo8, ov8, busy8, done8, bo16, ov16, busy16, done16;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  pd8 = '0;
    logic        pb8 = 1'b0, po8 = 1'b0;
    logic [15:0] pd16 = '0;
    logic        pb16 = 1'b0, po16 = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow_out(bo8), .ovf(ov8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .diff(diff16), .borrow_out(bo16), .ovf(ov16), .busy(busy16), .done(done16)
    );

    // Reference: returns {ovf, borrow, diff} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] model(input int w, input longint x, input longint y);
        longint half, full, sx, sy, s;
        logic [15:0] dd;
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        sx = (x >= half) ? x - full : x;
        sy = (y >= half) ? y - full : y;
        s  = sx - sy;
        dd = 16'((x - y + full) % full);
        return {(s >= half) || (s < -half), x < y, dd};
    endfunction

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] hd, input logic hb, input logic ho,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int bc, output int lat, output int hbad);
        @(negedge clk);
        start8 = 1'b1; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        bc = 0; lat = 0; hbad = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            if (diff8 !== hd || bo8 !== hb || ov8 !== ho) hbad++;
            lat++;
            @(negedge clk);
        end
        d = diff8; bo = bo8; ov = ov8;
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] hd, input logic hb, input logic ho,
                        output logic [15:0] d, output logic bo, output logic ov,
                        output int lat, output int hbad);
        @(negedge clk);
        start16 = 1'b1; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0; hbad = 0;
        while (!done16 && lat < 60) begin
            if (diff16 !== hd || bo16 !== hb || ov16 !== ho) hbad++;
            lat++;
            @(negedge clk);
        end
        d = diff16; bo = bo16; ov = ov16;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({diff8, bo8, ov8, busy8, done8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset8: got diff=%h bo=%b ovf=%b busy=%b done=%b, want all 0", diff8, bo8, ov8, busy8, done8);
        end
        n_chk++;
        if ({diff16, bo16, ov16, busy16, done16} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset16: got diff=%h bo=%b ovf=%b busy=%b done=%b, want all 0", diff16, bo16, ov16, busy16, done16);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [5] = '{8'h5A, 8'h00, 8'hA5, 8'h80, 8'h7F};
        logic [7:0] tb [5] = '{8'h3C, 8'h01, 8'hA5, 8'h01, 8'hFF};
        logic [9:0] te [5] = '{{2'b00, 8'h1E}, {2'b10, 8'hFF}, {2'b00, 8'h00}, {2'b01, 8'h7F}, {2'b11, 8'h80}};
        logic [7:0] d;
        logic bo, ov;
        int bc, lat, hbad;
        for (int i = 0; i < 5; i++) begin
            op8(ta[i], tb[i], pd8, pb8, po8, d, bo, ov, bc, lat, hbad);
            n_chk++;
            if ({bo, ov, d} !== te[i]) begin
                n_fail++;
                $display("FAIL directed[%0d]: got bo=%b ovf=%b diff=%h, want bo=%b ovf=%b diff=%h",
                         i, bo, ov, d, te[i][9], te[i][8], te[i][7:0]);
            end
            n_chk++;
            if (lat != 8 || bc != 8 || hbad != 0) begin
                n_fail++;
                $display("FAIL timing[%0d]: got latency=%0d busy=%0d hold_err=%0d, want 8 8 0", i, lat, bc, hbad);
            end
            @(negedge clk);
            n_chk++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || {bo8, ov8, diff8} !== te[i]) begin
                n_fail++;
                $display("FAIL after_done[%0d]: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                         i, done8, busy8, diff8, te[i][7:0]);
            end
            {pb8, po8, pd8} = te[i];
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra [40], rb [40];
        logic [17:0] m;
        int k;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            k = n % 10;
            if (n >= 1) begin
                n_chk++;
                if (done8 !== (k == 9) || busy8 !== (k >= 1 && k <= 8)) begin
                    n_fail++;
                    $display("FAIL b2b_hs[%0d]: got done=%b busy=%b, want done=%b busy=%b",
                             n, done8, busy8, k == 9, k >= 1 && k <= 8);
                end
                if (k == 9) begin
                    m = model(8, longint'(ra[n-9]), longint'(rb[n-9]));
                    {po8, pb8} = m[17:16];
                    pd8 = m[7:0];
                end
                n_chk++;
                if (diff8 !== pd8 || bo8 !== pb8 || ov8 !== po8) begin
                    n_fail++;
                    $display("FAIL b2b_res[%0d]: got diff=%h bo=%b ovf=%b, want diff=%h bo=%b ovf=%b",
                             n, diff8, bo8, ov8, pd8, pb8, po8);
                end
            end
            ra[n] = 8'($urandom); rb[n] = 8'($urandom);
            start8 = 1'b1; a8 = ra[n]; b8 = rb[n];
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic bo, ov;
        int bc, lat, hbad, spurious;
        op8(8'h5A, 8'h3C, pd8, pb8, po8, d, bo, ov, bc, lat, hbad);
        pd8 = 8'h1E; pb8 = 1'b0; po8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({diff8, bo8, ov8, busy8, done8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got diff=%h bo=%b ovf=%b busy=%b done=%b, want all 0", diff8, bo8, ov8, busy8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) spurious++;
        end
        n_chk++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL reset_nodone: got %0d cycles with done/busy, want 0", spurious);
        end
        op8(8'h10, 8'h20, 8'h00, 1'b0, 1'b0, d, bo, ov, bc, lat, hbad);
        n_chk++;
        if (d !== 8'hF0 || bo !== 1'b1 || ov !== 1'b0 || lat != 8 || hbad != 0) begin
            n_fail++;
            $display("FAIL post_reset: got diff=%h bo=%b ovf=%b lat=%0d hold_err=%0d, want diff=f0 bo=1 ovf=0 lat=8 hold_err=0",
                     d, bo, ov, lat, hbad);
        end
        pd8 = 8'hF0; pb8 = 1'b1; po8 = 1'b0;
    endtask

    task automatic test_random8();
        logic [7:0] x, y, d;
        logic bo, ov;
        logic [17:0] m;
        int bc, lat, hbad;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            m = model(8, longint'(x), longint'(y));
            op8(x, y, pd8, pb8, po8, d, bo, ov, bc, lat, hbad);
            n_chk++;
            if ({ov, bo, d} !== {m[17:16], m[7:0]} || lat != 8) begin
                n_fail++;
                $display("FAIL rand8[%0d] %h-%h: got diff=%h bo=%b ovf=%b lat=%0d, want diff=%h bo=%b ovf=%b lat=8",
                         i, x, y, d, bo, ov, lat, m[7:0], m[16], m[17]);
            end
            n_chk++;
            if (hbad != 0) begin
                n_fail++;
                $display("FAIL hold8[%0d]: got %0d cycles with changed outputs, want 0", i, hbad);
            end
            {po8, pb8} = m[17:16];
            pd8 = m[7:0];
        end
    endtask

    task automatic test_random16();
        logic [15:0] x, y, d;
        logic bo, ov;
        logic [17:0] m;
        int lat, hbad;
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            if (i < 4) begin
                x = (i < 2) ? 16'h8000 : 16'h0000;
                y = (i == 0) ? 16'h0001 : (i == 1) ? 16'h8000 : (i == 2) ? 16'hFFFF : 16'h0001;
            end
            m = model(16, longint'(x), longint'(y));
            op16(x, y, pd16, pb16, po16, d, bo, ov, lat, hbad);
            n_chk++;
            if ({ov, bo, d} !== m || lat != 16) begin
                n_fail++;
                $display("FAIL rand16[%0d] %h-%h: got diff=%h bo=%b ovf=%b lat=%0d, want diff=%h bo=%b ovf=%b lat=16",
                         i, x, y, d, bo, ov, lat, m[15:0], m[16], m[17]);
            end
            n_chk++;
            if (hbad != 0) begin
                n_fail++;
                $display("FAIL hold16[%0d]: got %0d cycles with changed outputs, want 0", i, hbad);
            end
            {po16, pb16, pd16} = m;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
